quad_cmd_gen: RTL and testbench

Quadrature-encoder front end that sits directly upstream of the up/down preset counter.
- Synchronises and glitch-filters encoder channels A, B and INDEX.
- Decodes Gray-code steps into single-cycle count-up / count-down commands.
- Issues an index-triggered preset and a pause level for the counter.
- Guarantees at most one of up / down / preset is asserted per cycle, so downstream command priority never matters.

---
 rtl/quad_cmd_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_quad_cmd_gen.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_cmd_gen.sv
// -----------------------------------------------------------------------------
// quad_cmd_gen
//
// Quadrature-encoder front end for the up/down preset counter.
// Synchronises and glitch-filters encoder A, B and INDEX, decodes Gray-code
// steps into single-cycle up/down commands, turns a filtered INDEX rising
// edge into a preset command, and registers hold_req as a pause level.
// At most one of enable_cnt_up / enable_cnt_dn / new_cntr_preset is high in
// any cycle, so the counter's command priority never matters.
//
// There is no valid/ready handshake on this block: every command output is a
// registered one-cycle pulse that the counter consumes unconditionally.
//
// Ports:
//   clk                    system clock, rising edge
//   rst                    synchronous reset, active high
//   enc_a, enc_b           encoder channels (asynchronous)
//   enc_index              encoder index pulse (asynchronous)
//   index_en               enables index-triggered preset
//   hold_req               request to freeze counting
//   preset_value           value loaded into the counter on an index event
//   err_clr                clears err_count
//   enable_cnt_up          one-cycle pulse: one step forward
//   enable_cnt_dn          one-cycle pulse: one step backward
//   new_cntr_preset        one-cycle pulse: load new_cntr_preset_value
//   new_cntr_preset_value  preset value captured on the last index event
//   pause_counting         hold_req delayed one cycle
//   dir                    last valid direction, 1 = up
//   err_illegal            one-cycle pulse on an illegal AB transition
//   err_count              saturating count of illegal transitions
//
// The FSM state is held in state_q (ST_INIT / ST_TRACK) for checkers to bind.
// -----------------------------------------------------------------------------
module quad_cmd_gen #(
   parameter int WIDETH   = 8,
   parameter int FILT_LEN = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enc_a,
   input  logic              enc_b,
   input  logic              enc_index,
   input  logic              index_en,
   input  logic              hold_req,
   input  logic [WIDETH-1:0] preset_value,
   input  logic              err_clr,
   output logic              enable_cnt_up,
   output logic              enable_cnt_dn,
   output logic              new_cntr_preset,
   output logic [WIDETH-1:0] new_cntr_preset_value,
   output logic              pause_counting,
   output logic              dir,
   output logic              err_illegal,
   output logic [7:0]        err_count
);

   localparam int         INIT_LEN  = 2 + FILT_LEN;
   localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
   localparam logic [4:0] INIT_LAST = 5'(INIT_LEN - 1);

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   // Channel order in all 3-bit vectors: {index, a, b}
   logic [2:0] raw_in;
   logic [2:0] sync1_q;
   logic [2:0] sync2_q;
   logic [2:0] filt_q;
   logic [2:0] filt_nxt;
   logic [3:0] filt_cnt_q   [3];
   logic [3:0] filt_cnt_nxt [3];

   state_t     state_q;
   state_t     state_nxt;
   logic [4:0] init_cnt_q;

   logic       in_track;
   logic [1:0] ab_load;
   logic       idx_load;

   logic [1:0] ab_q;
   logic       idx_q;
   logic       step_fwd;
   logic       step_rev;
   logic       step_ill;
   logic       preset_evt;
   logic       up_evt;
   logic       dn_evt;
   logic       err_evt;

   assign raw_in = {enc_index, enc_a, enc_b};

   // ---------------------------------------------------------------------------
   // Two-flop synchronisers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Glitch filters: the filtered level follows the synced level only after it
   // has differed for FILT_LEN consecutive cycles; any agreement restarts it.
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         filt_nxt[i]     = filt_q[i];
         filt_cnt_nxt[i] = '0;
         if (sync2_q[i] != filt_q[i]) begin
            if (filt_cnt_q[i] == FILT_LAST) begin
               filt_nxt[i] = sync2_q[i];
            end else begin
               filt_cnt_nxt[i] = filt_cnt_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= '0;
         for (int i = 0; i < 3; i++) begin
            filt_cnt_q[i] <= '0;
         end
      end else begin
         filt_q <= filt_nxt;
         for (int i = 0; i < 3; i++) begin
            filt_cnt_q[i] <= filt_cnt_nxt[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + 5'd1;
         end
      end
   end

   // FSM: next state. INIT covers the synchroniser + filter fill time.
   always_comb begin
      state_nxt = state_q;
      if (state_q == ST_INIT && init_cnt_q == INIT_LAST) begin
         state_nxt = ST_TRACK;
      end
   end

   // FSM: outputs. During INIT the stored AB/INDEX state takes the value the
   // filters are about to hold, so the level settled by the last INIT edge is
   // already the reference when TRACK starts and raises no spurious step.
   always_comb begin
      in_track = (state_q == ST_TRACK);
      ab_load  = in_track ? filt_q[1:0] : filt_nxt[1:0];
      idx_load = in_track ? filt_q[2]   : filt_nxt[2];
   end

   // ---------------------------------------------------------------------------
   // Step / index decode. Forward order is 00 -> 10 -> 11 -> 01 -> 00 ({a,b}).
   // ---------------------------------------------------------------------------
   always_comb begin
      step_fwd = 1'b0;
      step_rev = 1'b0;
      step_ill = 1'b0;
      case ({ab_q, filt_q[1:0]})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_rev = 1'b1;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_ill = 1'b1;
         default: ;
      endcase
      // Preset wins over a coincident step; pause only gates up/down.
      preset_evt = in_track & index_en & filt_q[2] & ~idx_q;
      up_evt     = in_track & step_fwd & ~preset_evt & ~pause_counting;
      dn_evt     = in_track & step_rev & ~preset_evt & ~pause_counting;
      err_evt    = in_track & step_ill;
   end

   // ---------------------------------------------------------------------------
   // Registered state and command outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ab_q                  <= '0;
         idx_q                 <= 1'b0;
         enable_cnt_up         <= 1'b0;
         enable_cnt_dn         <= 1'b0;
         new_cntr_preset       <= 1'b0;
         new_cntr_preset_value <= '0;
         pause_counting        <= 1'b0;
         dir                   <= 1'b1;
         err_illegal           <= 1'b0;
         err_count             <= '0;
      end else begin
         ab_q            <= ab_load;
         idx_q           <= idx_load;
         enable_cnt_up   <= up_evt;
         enable_cnt_dn   <= dn_evt;
         new_cntr_preset <= preset_evt;
         err_illegal     <= err_evt;
         pause_counting  <= hold_req;

         if (preset_evt) begin
            new_cntr_preset_value <= preset_value;
         end

         // Direction tracks every legal step, even when its pulse is dropped.
         if (in_track && step_fwd) begin
            dir <= 1'b1;
         end else if (in_track && step_rev) begin
            dir <= 1'b0;
         end

         if (err_clr) begin
            err_count <= '0;
         end else if (err_evt && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_quad_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_cmd_gen
//
// Drives encoder levels, keeps a reference model of the encoder position in
// Gray-code order, and pushes each expected pulse (with the cycle it must
// appear in) onto exp_q. A monitor pops and compares whenever a pulse output
// is high and flags expected pulses that never arrive.
// -----------------------------------------------------------------------------
module tb_quad_cmd_gen;

   localparam int WIDETH   = 8;
   localparam int FILT_LEN = 3;
   localparam int LAT      = 2 + FILT_LEN + 1;
   localparam int W        = 28;   // {cycle[15:0], up, dn, preset, err, value[7:0]}
   localparam logic [1:0] GRAY [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   logic              clk;
   logic              rst;
   logic              enc_a;
   logic              enc_b;
   logic              enc_index;
   logic              index_en;
   logic              hold_req;
   logic [WIDETH-1:0] preset_value;
   logic              err_clr;
   logic              enable_cnt_up;
   logic              enable_cnt_dn;
   logic              new_cntr_preset;
   logic [WIDETH-1:0] new_cntr_preset_value;
   logic              pause_counting;
   logic              dir;
   logic              err_illegal;
   logic [7:0]        err_count;

   quad_cmd_gen #(.WIDETH(WIDETH), .FILT_LEN(FILT_LEN)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .enc_a                 (enc_a),
      .enc_b                 (enc_b),
      .enc_index             (enc_index),
      .index_en              (index_en),
      .hold_req              (hold_req),
      .preset_value          (preset_value),
      .err_clr               (err_clr),
      .enable_cnt_up         (enable_cnt_up),
      .enable_cnt_dn         (enable_cnt_dn),
      .new_cntr_preset       (new_cntr_preset),
      .new_cntr_preset_value (new_cntr_preset_value),
      .pause_counting        (pause_counting),
      .dir                   (dir),
      .err_illegal           (err_illegal),
      .err_count             (err_count)
   );

   // ---------------------------------------------------------------------------
   // Clock / cycle counter
   // ---------------------------------------------------------------------------
   int cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // Scoreboard and reference model state
   // ---------------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   logic [1:0] m_ab;
   logic       m_dir;
   int         m_err;
   logic       m_pause;
   logic       m_idx;
   logic       m_idx_en;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int gray_pos(input logic [1:0] ab);
      int p = 0;
      for (int i = 0; i < 4; i++) if (GRAY[i] == ab) p = i;
      return p;
   endfunction

   // Apply a new accepted input level to the model; called right after the
   // driver changes inputs at a negedge. The pulse shows up LAT edges later.
   task automatic model_apply(input logic [1:0] new_ab, input logic idx_rise);
      logic up, dn, pre, er;
      int   c;
      up  = 1'b0;
      dn  = 1'b0;
      er  = 1'b0;
      pre = idx_rise && m_idx_en;
      if (new_ab != m_ab) begin
         if ((new_ab ^ m_ab) == 2'b11) begin
            er = 1'b1;
            if (m_err < 255) m_err++;
         end else if (gray_pos(new_ab) == (gray_pos(m_ab) + 1) % 4) begin
            m_dir = 1'b1;
            up    = !pre && !m_pause;
         end else begin
            m_dir = 1'b0;
            dn    = !pre && !m_pause;
         end
      end
      m_ab = new_ab;
      if (up || dn || pre || er) begin
         c = cyc + LAT;
         exp_q.push_back({c[15:0], up, dn, pre, er, pre ? preset_value : 8'h00});
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic step_to(input logic [1:0] new_ab, input logic idx_level, input int gap);
      logic rise;
      @(negedge clk);
      rise      = idx_level & ~m_idx;
      enc_a     = new_ab[1];
      enc_b     = new_ab[0];
      enc_index = idx_level;
      model_apply(new_ab, rise);
      m_idx = idx_level;
      wait_cyc(gap);
   endtask

   function automatic logic [1:0] next_fwd(input logic [1:0] ab);
      return GRAY[(gray_pos(ab) + 1) % 4];
   endfunction

   function automatic logic [1:0] next_rev(input logic [1:0] ab);
      return GRAY[(gray_pos(ab) + 3) % 4];
   endfunction

   task automatic glitch_a(input int len);
      @(negedge clk);
      enc_a = ~enc_a;
      wait_cyc(len);
      enc_a = ~enc_a;
      wait_cyc(8);
   endtask

   task automatic set_hold(input logic v);
      @(negedge clk);
      hold_req = v;
      #1;
      check("pause_before_edge", {31'd0, pause_counting}, {31'd0, m_pause});
      @(negedge clk);
      m_pause = v;
      check("pause_after_edge", {31'd0, pause_counting}, {31'd0, v});
      wait_cyc(2);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_up"},        {31'd0, enable_cnt_up},         32'd0);
      check({tag, "_dn"},        {31'd0, enable_cnt_dn},         32'd0);
      check({tag, "_preset"},    {31'd0, new_cntr_preset},       32'd0);
      check({tag, "_value"},     {24'd0, new_cntr_preset_value}, 32'd0);
      check({tag, "_pause"},     {31'd0, pause_counting},        32'd0);
      check({tag, "_dir"},       {31'd0, dir},                   32'd1);
      check({tag, "_err"},       {31'd0, err_illegal},           32'd0);
      check({tag, "_err_count"}, {24'd0, err_count},             32'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compares every observed pulse with the head of exp_q
   // ---------------------------------------------------------------------------
   logic [W-1:0] mon_obs;
   logic [W-1:0] mon_exp;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0][27:12] < cyc[15:0]) begin
         mon_exp = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_pulse: got none expected %0h", mon_exp);
      end
      if (enable_cnt_up || enable_cnt_dn || new_cntr_preset || err_illegal) begin
         mon_obs = {cyc[15:0], enable_cnt_up, enable_cnt_dn, new_cntr_preset, err_illegal,
                    new_cntr_preset ? new_cntr_preset_value : 8'h00};
         checks++;
         if ((32'(enable_cnt_up) + 32'(enable_cnt_dn) + 32'(new_cntr_preset)) > 1) begin
            errors++;
            $display("FAIL exclusive: got %0h expected at most one command", mon_obs);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got %0h expected none", mon_obs);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_obs !== mon_exp) begin
               errors++;
               $display("FAIL pulse: got %0h expected %0h", mon_obs, mon_exp);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [1:0] nab;
      int         op;
      rst          = 1'b1;
      enc_a        = 1'b1;
      enc_b        = 1'b1;
      enc_index    = 1'b0;
      index_en     = 1'b0;
      hold_req     = 1'b0;
      preset_value = '0;
      err_clr      = 1'b0;
      wait_cyc(3);
      check_reset_outputs("reset");

      rst      = 1'b0;
      m_ab     = 2'b11;
      m_dir    = 1'b1;
      m_err    = 0;
      m_pause  = 1'b0;
      m_idx    = 1'b0;
      m_idx_en = 1'b0;
      wait_cyc(12);

      // Forward 11 -> 01 after INIT
      step_to(2'b01, 1'b0, 10);
      check("dir_fwd", {31'd0, dir}, 32'd1);

      // To 00, then four reverse steps
      step_to(2'b00, 1'b0, 10);
      step_to(2'b01, 1'b0, 10);
      step_to(2'b11, 1'b0, 10);
      step_to(2'b10, 1'b0, 10);
      step_to(2'b00, 1'b0, 10);
      check("dir_rev", {31'd0, dir}, 32'd0);
      check("err_count_clean", {24'd0, err_count}, 32'd0);

      // Short glitch is rejected; a stable change is accepted
      glitch_a(FILT_LEN - 1);
      step_to(2'b10, 1'b0, 10);
      check("dir_after_glitch", {31'd0, dir}, 32'd1);

      // 300 illegal transitions, saturation, clear
      step_to(2'b00, 1'b0, 10);
      for (int i = 0; i < 300; i++) begin
         step_to(~m_ab, 1'b0, 6);
      end
      wait_cyc(4);
      check("err_count_sat", {24'd0, err_count}, m_err);
      check("dir_after_illegal", {31'd0, dir}, {31'd0, m_dir});
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err   = 0;
      check("err_clr", {24'd0, err_count}, 32'd0);

      // Index coincident with a forward step
      index_en     = 1'b1;
      m_idx_en     = 1'b1;
      preset_value = 8'h5A;
      step_to(next_fwd(m_ab), 1'b1, 10);
      check("dir_preset", {31'd0, dir}, 32'd1);
      check("preset_value", {24'd0, new_cntr_preset_value}, 32'h5A);
      step_to(m_ab, 1'b0, 10);

      // Pause across three forward steps, then one step after release
      set_hold(1'b1);
      for (int i = 0; i < 3; i++) step_to(next_fwd(m_ab), 1'b0, 10);
      set_hold(1'b0);
      step_to(next_fwd(m_ab), 1'b0, 10);

      // Reset while a step is in the pipeline
      @(negedge clk);
      nab   = next_fwd(m_ab);
      enc_a = nab[1];
      enc_b = nab[0];
      wait_cyc(2);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      rst     = 1'b0;
      m_ab    = nab;
      m_dir   = 1'b1;
      m_err   = 0;
      m_idx   = enc_index;
      m_pause = 1'b0;
      wait_cyc(15);

      // Randomized mix
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 6);
         case (op)
            0, 1: step_to(next_fwd(m_ab), 1'b0, $urandom_range(8, 14));
            2:    step_to(next_rev(m_ab), 1'b0, $urandom_range(8, 14));
            3:    glitch_a($urandom_range(1, FILT_LEN - 1));
            4:    step_to(~m_ab, 1'b0, $urandom_range(8, 14));
            5: begin
               @(negedge clk);
               index_en     = 1'($urandom_range(0, 1));
               m_idx_en     = index_en;
               preset_value = 8'($urandom_range(0, 255));
               wait_cyc(2);
               if ($urandom_range(0, 1) == 1)
                  step_to(next_fwd(m_ab), 1'b1, 10);
               else
                  step_to(m_ab, 1'b1, 10);
               step_to(m_ab, 1'b0, 10);
            end
            default: set_hold(~hold_req);
         endcase
      end
      if (hold_req) set_hold(1'b0);
      wait_cyc(20);

      check("queue_empty", exp_q.size(), 32'd0);
      check("final_err_count", {24'd0, err_count}, m_err);
      check("final_dir", {31'd0, dir}, {31'd0, m_dir});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
